// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
// Bundle between the multi-cycle controller and the datapath / memory port.
//   opcode    : IR[31:26] (OP_W bits), driven by the datapath
//   zero      : ALU zero flag, driven by the datapath
//   mem_ready : memory access complete this cycle, driven by the memory port
//   ctrl      : {RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg, Jump, Branch}
//   ir_write  : load the instruction register
//   pc_write  : load the PC
//   alu_op    : 00 add, 01 sub/compare, 10 funct-decoded, 11 immediate-op
// The master modport is the controller side, the slave modport the datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int OP_W = 6
) ();
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;
  logic [7:0]      ctrl;
  logic            ir_write;
  logic            pc_write;
  logic [1:0]      alu_op;

  modport master (
    input  opcode, zero, mem_ready,
    output ctrl, ir_write, pc_write, alu_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  ctrl, ir_write, pc_write, alu_op
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle MIPS control FSM: FETCH -> DECODE -> execute/memory/writeback.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : controller side of mips_multicycle_ctrl_if (opcode, zero,
//              mem_ready in; ctrl, ir_write, pc_write, alu_op out)
//   state    : current state encoding (debug)
//   illegal  : sticky illegal-opcode flag, cleared only by reset
//   retired  : retired-instruction count, wraps modulo 2^CNT_W
// The interface instance must be built with the same OP_W as this module.
module mips_multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int CNT_W   = 32,
  parameter int HAS_IMM = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_multicycle_ctrl_if.master bus,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [CNT_W-1:0]     retired
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_RTWB    = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  // ctrl bit positions
  localparam int B_REGDST   = 7;
  localparam int B_REGWRITE = 6;
  localparam int B_ALUSRC   = 5;
  localparam int B_MEMREAD  = 4;
  localparam int B_MEMWRITE = 3;
  localparam int B_MEMTOREG = 2;
  localparam int B_JUMP     = 1;
  localparam int B_BRANCH   = 0;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t          cur;
  state_t          nxt;
  logic [7:0]      ctrl_dec;
  logic            ir_write_dec;
  logic            pc_write_dec;
  logic [1:0]      alu_op_dec;
  logic            retire;
  logic [5:0]      op6;
  logic            upper_nz;

  assign op6 = bus.opcode[5:0];

  // Opcode bits above the 6-bit MIPS field make the instruction illegal.
  if (OP_W > 6) begin : g_upper
    assign upper_nz = |bus.opcode[OP_W-1:6];
  end else begin : g_no_upper
    assign upper_nz = 1'b0;
  end

  // Maps an opcode to the first state after DECODE.
  function automatic state_t decode_op(input logic [5:0] op, input logic up_nz);
    state_t s;
    s = S_TRAP;
    if (up_nz) begin
      s = S_TRAP;
    end else begin
      casez (op)
        6'b000000: s = S_RTEXEC;
        6'b00001?: s = S_JUMP;                       // j, jal
        6'b00010?: s = S_BRANCH;                     // beq, bne
        6'b001???: s = (HAS_IMM != 0) ? S_IMMEXEC : S_TRAP;
        6'b10000?,                                   // lb, lh
        6'b100011,                                   // lw
        6'b10010?,                                   // lbu, lhu
        6'b10100?,                                   // sb, sh
        6'b101011: s = S_MEMADR;                     // sw
        default:   s = S_TRAP;
      endcase
    end
    return s;
  endfunction

  // State register; reset returns to FETCH and abandons any pending access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= S_FETCH;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    nxt          = S_FETCH;
    ctrl_dec     = 8'd0;
    ir_write_dec = 1'b0;
    pc_write_dec = 1'b0;
    alu_op_dec   = 2'b00;
    retire       = 1'b0;
    case (cur)
      S_FETCH: begin
        ctrl_dec[B_MEMREAD] = 1'b1;
        if (bus.mem_ready) begin
          ir_write_dec = 1'b1;
          pc_write_dec = 1'b1;
          nxt          = S_DECODE;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        nxt = decode_op(op6, upper_nz);
      end
      S_MEMADR: begin
        ctrl_dec[B_ALUSRC] = 1'b1;
        // Stores are the 101xxx group, distinguished by opcode bit 3.
        nxt = op6[3] ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl_dec[B_MEMREAD] = 1'b1;
        nxt = bus.mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ctrl_dec[B_REGWRITE] = 1'b1;
        ctrl_dec[B_MEMTOREG] = 1'b1;
        retire               = 1'b1;
        nxt                  = S_FETCH;
      end
      S_MEMWR: begin
        ctrl_dec[B_MEMWRITE] = 1'b1;
        if (bus.mem_ready) begin
          retire = 1'b1;
          nxt    = S_FETCH;
        end else begin
          nxt = S_MEMWR;
        end
      end
      S_RTEXEC: begin
        alu_op_dec = 2'b10;
        nxt        = S_RTWB;
      end
      S_RTWB: begin
        ctrl_dec[B_REGDST]   = 1'b1;
        ctrl_dec[B_REGWRITE] = 1'b1;
        retire               = 1'b1;
        nxt                  = S_FETCH;
      end
      S_IMMEXEC: begin
        ctrl_dec[B_ALUSRC] = 1'b1;
        alu_op_dec         = 2'b11;
        nxt                = S_IMMWB;
      end
      S_IMMWB: begin
        ctrl_dec[B_REGWRITE] = 1'b1;
        retire               = 1'b1;
        nxt                  = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_dec[B_BRANCH] = 1'b1;
        alu_op_dec         = 2'b01;
        // bne (opcode bit 0 set) takes the branch on !zero, beq on zero.
        pc_write_dec = op6[0] ? ~bus.zero : bus.zero;
        retire       = 1'b1;
        nxt          = S_FETCH;
      end
      S_JUMP: begin
        ctrl_dec[B_JUMP]     = 1'b1;
        ctrl_dec[B_REGWRITE] = op6[0];               // jal links
        pc_write_dec         = 1'b1;
        retire               = 1'b1;
        nxt                  = S_FETCH;
      end
      S_TRAP: begin
        nxt = S_TRAP;
      end
      default: begin
        nxt = S_FETCH;
      end
    endcase
  end

  // Sticky illegal flag, raised on the same edge that enters TRAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (nxt == S_TRAP) begin
      illegal <= 1'b1;
    end else begin
      illegal <= illegal;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= {CNT_W{1'b0}};
    end else if (retire) begin
      retired <= retired + CNT_ONE;
    end else begin
      retired <= retired;
    end
  end

  // Strobes are forced low while reset is held, since FETCH would otherwise
  // present MemRead during reset.
  assign bus.ctrl     = rst_n ? ctrl_dec     : 8'd0;
  assign bus.ir_write = rst_n ? ir_write_dec : 1'b0;
  assign bus.pc_write = rst_n ? pc_write_dec : 1'b0;
  assign bus.alu_op   = rst_n ? alu_op_dec   : 2'b00;
  assign state        = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Directed bench for mips_multicycle_ctrl. dut_a: OP_W=8, CNT_W=4, HAS_IMM=1.
// dut_b: OP_W=6, CNT_W=32, HAS_IMM=0 (shares clock, reset, mem_ready, zero).
// Each cycle the expected {state, ctrl, alu_op, ir_write, pc_write} is queued
// as the inputs are driven and popped when the outputs are sampled.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  state_a;
  logic [3:0]  state_b;
  logic        ill_a;
  logic        ill_b;
  logic [3:0]  ret_a;
  logic [31:0] ret_b;

  mips_multicycle_ctrl_if #(.OP_W(8)) ifa ();
  mips_multicycle_ctrl_if #(.OP_W(6)) ifb ();

  mips_multicycle_ctrl #(.OP_W(8), .CNT_W(4), .HAS_IMM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .state(state_a), .illegal(ill_a), .retired(ret_a)
  );

  mips_multicycle_ctrl #(.OP_W(6), .CNT_W(32), .HAS_IMM(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .state(state_b), .illegal(ill_b), .retired(ret_b)
  );

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_MRD  = 8'b0001_0000;
  localparam logic [7:0] C_ADR  = 8'b0010_0000;
  localparam logic [7:0] C_MWB  = 8'b0100_0100;
  localparam logic [7:0] C_MWR  = 8'b0000_1000;
  localparam logic [7:0] C_RWB  = 8'b1100_0000;
  localparam logic [7:0] C_IWB  = 8'b0100_0000;
  localparam logic [7:0] C_BR   = 8'b0000_0001;
  localparam logic [7:0] C_JAL  = 8'b0100_0010;
  localparam logic [7:0] C_J    = 8'b0000_0010;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] ev(input logic [3:0] st, input logic [7:0] c,
                                     input logic [1:0] a, input logic irw, input logic pcw);
    return {st, c, a, irw, pcw};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs, compare outputs 1 time unit later, then move to the next negedge.
  task automatic cyc(input string tag, input logic mr, input logic zr, input logic [15:0] e);
    logic [15:0] got;
    logic [15:0] want;
    ifa.mem_ready = mr;
    ifa.zero      = zr;
    ifb.mem_ready = mr;
    ifb.zero      = zr;
    exp_q.push_back(e);
    #1;
    got  = {state_a, ifa.ctrl, ifa.alu_op, ifa.ir_write, ifa.pc_write};
    want = exp_q.pop_front();
    check(tag, {16'd0, got}, {16'd0, want});
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    rst_n         = 1'b0;
    ifa.mem_ready = 1'b0;
    ifb.mem_ready = 1'b0;
    #1;
    check({tag, "_vec"}, {16'd0, state_a, ifa.ctrl, ifa.alu_op, ifa.ir_write, ifa.pc_write}, 32'd0);
    check({tag, "_retired"}, {28'd0, ret_a}, 32'd0);
    check({tag, "_illegal"}, {31'd0, ill_a}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    ifa.opcode    = 8'h00;
    ifa.mem_ready = 1'b0;
    ifa.zero      = 1'b0;
    ifb.opcode    = 6'h08;  // addi, illegal when HAS_IMM=0
    ifb.mem_ready = 1'b0;
    ifb.zero      = 1'b0;
    @(negedge clk);
    do_reset("reset0");

    // R-type
    ifa.opcode = 8'h00;
    cyc("rt_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD,  2'b00, 1'b1, 1'b1));
    cyc("rt_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    check("b_addi_trap_state", {28'd0, state_b}, 32'd12);
    check("b_addi_illegal", {31'd0, ill_b}, 32'd1);
    cyc("rt_exec",   1'b1, 1'b0, ev(4'd6, C_NONE, 2'b10, 1'b0, 1'b0));
    cyc("rt_wb",     1'b1, 1'b0, ev(4'd7, C_RWB,  2'b00, 1'b0, 1'b0));
    cyc("rt_idle",   1'b0, 1'b0, ev(4'd0, C_MRD,  2'b00, 1'b0, 1'b0));
    check("rt_retired", {28'd0, ret_a}, 32'd1);

    // lw with three wait cycles in MEMRD
    ifa.opcode = 8'h23;
    cyc("lw_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("lw_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("lw_memadr", 1'b1, 1'b0, ev(4'd2, C_ADR, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 1'b0, 1'b0, ev(4'd3, C_MRD, 2'b00, 1'b0, 1'b0));
    cyc("lw_rd_done", 1'b1, 1'b0, ev(4'd3, C_MRD, 2'b00, 1'b0, 1'b0));
    cyc("lw_memwb",   1'b0, 1'b0, ev(4'd4, C_MWB, 2'b00, 1'b0, 1'b0));
    cyc("lw_idle",    1'b0, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b0, 1'b0));
    check("lw_retired", {28'd0, ret_a}, 32'd2);

    // sw with one wait cycle in MEMWR
    ifa.opcode = 8'h2B;
    cyc("sw_fetch",   1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("sw_decode",  1'b0, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("sw_memadr",  1'b1, 1'b0, ev(4'd2, C_ADR, 2'b00, 1'b0, 1'b0));
    cyc("sw_wr_wait", 1'b0, 1'b0, ev(4'd5, C_MWR, 2'b00, 1'b0, 1'b0));
    cyc("sw_wr_done", 1'b1, 1'b0, ev(4'd5, C_MWR, 2'b00, 1'b0, 1'b0));
    cyc("sw_idle",    1'b0, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b0, 1'b0));
    check("sw_retired", {28'd0, ret_a}, 32'd3);

    // beq taken, beq not taken, bne taken
    ifa.opcode = 8'h04;
    cyc("beq1_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("beq1_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("beq1_branch", 1'b1, 1'b1, ev(4'd8, C_BR, 2'b01, 1'b0, 1'b1));
    cyc("beq0_fetch",  1'b1, 1'b1, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("beq0_decode", 1'b1, 1'b1, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("beq0_branch", 1'b1, 1'b0, ev(4'd8, C_BR, 2'b01, 1'b0, 1'b0));
    ifa.opcode = 8'h05;
    cyc("bne_fetch",   1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("bne_decode",  1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("bne_branch",  1'b1, 1'b0, ev(4'd8, C_BR, 2'b01, 1'b0, 1'b1));
    check("br_retired", {28'd0, ret_a}, 32'd6);

    // jal then j
    ifa.opcode = 8'h03;
    cyc("jal_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("jal_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("jal_jump",   1'b1, 1'b0, ev(4'd9, C_JAL, 2'b00, 1'b0, 1'b1));
    ifa.opcode = 8'h02;
    cyc("j_fetch",    1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("j_decode",   1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("j_jump",     1'b0, 1'b0, ev(4'd9, C_J, 2'b00, 1'b0, 1'b1));
    check("jmp_retired", {28'd0, ret_a}, 32'd8);

    // addi with HAS_IMM=1
    ifa.opcode = 8'h08;
    cyc("addi_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("addi_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("addi_exec",   1'b1, 1'b0, ev(4'd10, C_ADR, 2'b11, 1'b0, 1'b0));
    cyc("addi_wb",     1'b1, 1'b0, ev(4'd11, C_IWB, 2'b00, 1'b0, 1'b0));
    cyc("addi_idle",   1'b0, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b0, 1'b0));
    check("addi_retired", {28'd0, ret_a}, 32'd9);

    // Illegal opcode 111111: TRAP is sticky
    ifa.opcode = 8'h3F;
    cyc("trap_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("trap_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    check("trap_illegal_entry", {31'd0, ill_a}, 32'd1);
    for (int i = 0; i < 20; i++) cyc("trap_hold", 1'b1, 1'b1, ev(4'd12, C_NONE, 2'b00, 1'b0, 1'b0));
    check("trap_illegal_held", {31'd0, ill_a}, 32'd1);
    check("trap_retired", {28'd0, ret_a}, 32'd9);
    do_reset("reset_trap");

    // Nonzero upper opcode bits are illegal even if the low field is R-type
    ifa.opcode = 8'h40;
    cyc("upper_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("upper_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("upper_trap",   1'b1, 1'b0, ev(4'd12, C_NONE, 2'b00, 1'b0, 1'b0));
    check("upper_illegal", {31'd0, ill_a}, 32'd1);
    do_reset("reset_upper");

    // 16 jumps wrap the 4-bit counter to zero
    ifa.opcode = 8'h02;
    for (int i = 0; i < 16; i++) begin
      cyc("wrap_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
      cyc("wrap_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
      cyc("wrap_jump",   1'b0, 1'b0, ev(4'd9, C_J, 2'b00, 1'b0, 1'b1));
      if (i == 14) check("wrap_retired_15", {28'd0, ret_a}, 32'd15);
    end
    check("wrap_retired_0", {28'd0, ret_a}, 32'd0);

    // Reset while a store waits in MEMWR
    ifa.opcode = 8'h2B;
    cyc("rsw_fetch",  1'b1, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b1, 1'b1));
    cyc("rsw_decode", 1'b1, 1'b0, ev(4'd1, C_NONE, 2'b00, 1'b0, 1'b0));
    cyc("rsw_memadr", 1'b0, 1'b0, ev(4'd2, C_ADR, 2'b00, 1'b0, 1'b0));
    cyc("rsw_wait",   1'b0, 1'b0, ev(4'd5, C_MWR, 2'b00, 1'b0, 1'b0));
    cyc("rsw_wait2",  1'b0, 1'b0, ev(4'd5, C_MWR, 2'b00, 1'b0, 1'b0));
    do_reset("reset_memwr");
    cyc("post_fetch", 1'b0, 1'b0, ev(4'd0, C_MRD, 2'b00, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
